mem_stage_hs: RTL and testbench
===============================

// Module: mem_stage_hs
// PURPOSE
//  Parametrised MEM pipeline stage. Sits between the EX/MEM and MEM/WB pipeline registers.
//  Drives a req/ack external data-memory port with wait states and a timeout.
//  Supports byte/half/word loads (sign- or zero-extended) and byte-enable stores.
//  Stalls the upstream pipeline while a memory access is in flight.
//  Selects the write-back value and registers it into mem_wb.
// PARAMETERS
//  ADDR_W   32  byte-address width of alu_s / mem_addr
//  REG_AW   5   register-index width
//  TIMEOUT  15  max BUSY cycles waiting for mem_ack before bus error (1..255)
// PORTS
//  clk           in   1               clock, rising edge
//  reset_b       in   1               reset, asynchronous, active-low
//  in_valid      in   1               EX/MEM slot holds a real instruction
//  mem_read      in   1               load
//  mem_write     in   1               store (mem_read & mem_write together: treated as store)
//  mem_size      in   2               00 byte, 01 half, 10 word, 11 reserved (=word)
//  mem_signed    in   1               1: sign-extend loads; 0: zero-extend
//  alu_s         in   ADDR_W          ALU result / byte address
//  mem_wdata_in  in   32              store data (right-aligned)
//  write_reg     in   REG_AW          destination register
//  reg_write     in   1               destination write enable
//  mem_to_reg    in   2               00 ALU, 01 load data, 1x pc_plus4
//  pc_plus4      in   32              return address
//  lu_op         in   1               select lu_data (overrides mem_to_reg)
//  lu_data       in   32              upper-immediate value
//  mem_req       out  1               memory request, held until mem_ack
//  mem_we        out  1               1 write, 0 read
//  mem_addr      out  ADDR_W          word-aligned address (alu_s with [1:0]=0)
//  mem_be        out  4               byte enables, little-endian
//  mem_wdata     out  32              lane-replicated store data
//  mem_ack       in   1               memory completes this cycle
//  mem_rdata     in   32              read word, valid when mem_ack=1
//  stall         out  1               upstream must hold its inputs and not advance
//  misalign_err  out  1               1-cycle pulse: misaligned access dropped
//  bus_err       out  1               1-cycle pulse: timeout expired
//  mem_wb        out  32+REG_AW+1     {reg_write, write_reg, wb_data}
// BEHAVIOUR
//  Reset: FSM=IDLE. mem_req, mem_we, mem_addr, mem_be, mem_wdata = 0. mem_wb = 0.
//   misalign_err, bus_err, and the timeout counter = 0. Reset deasserts mem_req immediately.
//  access = in_valid & (mem_read | mem_write).
//   misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
//  IDLE, no access: mem_wb <= {reg_write&in_valid, write_reg, wb_data}; stall=0 (1-cycle latency).
//  IDLE, access & misaligned: no request; mem_wb <= 0 (bubble); misalign_err=1 next cycle; stall=0.
//  IDLE, access & aligned: stall=1 (combinational); mem_wb <= 0.
//   Latch addr, we, be, wdata, size, signed, and dest/WB controls. Next state BUSY with mem_req=1.
//  BUSY: mem_req and all mem_* outputs stay stable; the counter increments each cycle.
//   No mem_ack: stall=1 and mem_wb <= 0. If the counter reaches TIMEOUT: bus_err pulse, mem_wb <= 0,
//   state <= IDLE, stall=0 in that cycle.
//   mem_ack: stall=0 and state <= IDLE, and mem_req drops on the next edge. mem_wb <= the latched
//   controls with wb_data; for a load, wb_data is the extracted lane. A store writes the register
//   only if the latched reg_write=1 (normally 0).
//  Minimum memory-op latency: 2 cycles (an ack on the first BUSY cycle).
//  Store lanes: byte be=4'b0001<<a[1:0], data replicated x4. Half be=a[1]?1100:0011, data
//   replicated x2. Word be=1111.
//  Load extract: byte rdata[8*a[1:0]+:8], half rdata[16*a[1]+:16], then extend per mem_signed.
//  wb_data = lu_op ? lu_data : mem_to_reg==00 ? alu_s : mem_to_reg==01 ? load_data : pc_plus4.
//   alu_s is zero-extended or truncated to 32.
//  Upstream changes to the inputs while stall=1 are ignored because the controls are latched.
//  Reset in BUSY aborts the access with no bus_err.
// TESTING
//  ALU op: lu_op=0, mem_to_reg=00, alu_s=0x1234, write_reg=7, reg_write=1 -> next cycle
//   mem_wb={1,7,0x1234}, stall=0.
//  Signed byte load: addr 0x103, rdata=0x80FFFF11, ack on 3rd BUSY cycle -> stall=1 for 3 cycles,
//   mem_be=0001<<3, mem_wb data=0xFFFFFF80.
//  Half store: addr 0x2002, wdata=0xABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x2000.
//  Misaligned word load at 0x5 -> mem_req stays 0, misalign_err pulse, mem_wb RegWrite=0.
//  No ack with TIMEOUT=15 -> bus_err after 15 BUSY cycles, stall drops, FSM back in IDLE.
//  reset_b low in BUSY -> mem_req=0 and mem_wb=0 immediately. After release, a fresh load completes normally.

Source files
------------

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM pipeline stage driving a req/ack data-memory port with timeout, load extract and write-back register.
module mem_stage_hs #(
  parameter int ADDR_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset_b,
  input  logic                   in_valid,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [1:0]             mem_size,
  input  logic                   mem_signed,
  input  logic [ADDR_W-1:0]      alu_s,
  input  logic [31:0]            mem_wdata_in,
  input  logic [REG_AW-1:0]      write_reg,
  input  logic                   reg_write,
  input  logic [1:0]             mem_to_reg,
  input  logic [31:0]            pc_plus4,
  input  logic                   lu_op,
  input  logic [31:0]            lu_data,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [3:0]             mem_be,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  output logic                   stall,
  output logic                   misalign_err,
  output logic                   bus_err,
  output logic [32+REG_AW:0]     mem_wb
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, stateNext;
  logic [31:0] aluIn, aluQ, pcQ, luDataQ, wdataNew;
  logic [3:0] beNew;
  logic [7:0] cnt;
  logic [1:0] sizeQ, offQ, memToRegQ;
  logic signedQ, regWriteQ, luOpQ, access, misaligned, start, tmo;
  logic [REG_AW-1:0] destQ;
  logic [32+REG_AW:0] wbNext;

  function automatic logic [31:0] loadExt(input logic [31:0] d, input logic [1:0] a,
                                          input logic [1:0] sz, input logic sg);
    logic [7:0] b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = d[{a[1], 4'b0000} +: 16];
    return sz == 2'b00 ? {{24{sg & b[7]}}, b} : sz == 2'b01 ? {{16{sg & h[15]}}, h} : d;
  endfunction

  function automatic logic [31:0] wbSel(input logic luOp, input logic [31:0] lu, input logic [1:0] m2r,
                                        input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc);
    return luOp ? lu : m2r == 2'b00 ? alu : m2r == 2'b01 ? ld : pc;
  endfunction

  if (ADDR_W >= 32) begin : g_trunc
    assign aluIn = alu_s[31:0];
  end else begin : g_zext
    assign aluIn = {{(32-ADDR_W){1'b0}}, alu_s};
  end

  always_comb begin
    access     = in_valid & (mem_read | mem_write);
    misaligned = (mem_size == 2'b01 & alu_s[0]) | (mem_size[1] & |alu_s[1:0]);
    start      = state == IDLE & access & ~misaligned;
    tmo        = state == BUSY & cnt == 8'(TIMEOUT - 1);
    beNew      = mem_size == 2'b00 ? 4'b0001 << alu_s[1:0] :
                 mem_size == 2'b01 ? (alu_s[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdataNew   = mem_size == 2'b00 ? {4{mem_wdata_in[7:0]}} :
                 mem_size == 2'b01 ? {2{mem_wdata_in[15:0]}} : mem_wdata_in;
    stall      = state == IDLE ? start : ~mem_ack & ~tmo;
    stateNext  = state == IDLE ? (start ? BUSY : IDLE) : (mem_ack | tmo ? IDLE : BUSY);
    wbNext     = '0;
    if (state == IDLE && !access)
      wbNext = {reg_write & in_valid, write_reg,
                wbSel(lu_op, lu_data, mem_to_reg, aluIn, loadExt(mem_rdata, alu_s[1:0], mem_size, mem_signed), pc_plus4)};
    else if (state == BUSY && mem_ack)
      wbNext = {regWriteQ, destQ,
                wbSel(luOpQ, luDataQ, memToRegQ, aluQ, loadExt(mem_rdata, offQ, sizeQ, signedQ), pcQ)};
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      mem_wb       <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      cnt          <= '0;
      sizeQ        <= '0;
      offQ         <= '0;
      signedQ      <= 1'b0;
      regWriteQ    <= 1'b0;
      destQ        <= '0;
      memToRegQ    <= '0;
      luOpQ        <= 1'b0;
      luDataQ      <= '0;
      aluQ         <= '0;
      pcQ          <= '0;
    end else begin
      state        <= stateNext;
      mem_wb       <= wbNext;
      misalign_err <= state == IDLE & access & misaligned;
      bus_err      <= tmo & ~mem_ack;
      cnt          <= state == BUSY ? cnt + 8'd1 : 8'd0;
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= mem_write;
        mem_addr  <= {alu_s[ADDR_W-1:2], 2'b00};
        mem_be    <= beNew;
        mem_wdata <= wdataNew;
        sizeQ     <= mem_size;
        offQ      <= alu_s[1:0];
        signedQ   <= mem_signed;
        regWriteQ <= reg_write;
        destQ     <= write_reg;
        memToRegQ <= mem_to_reg;
        luOpQ     <= lu_op;
        luDataQ   <= lu_data;
        aluQ      <= aluIn;
        pcQ       <= pc_plus4;
      end else if (state == BUSY && (mem_ack || tmo)) begin
        mem_req <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: directed self-checking bench for mem_stage_hs.
module tb_mem_stage_hs;
  localparam int ADDR_W = 32, REG_AW = 5, TIMEOUT = 15;
  logic clk = 1'b0, reset_b = 1'b0;
  logic in_valid = 0, mem_read = 0, mem_write = 0, mem_signed = 0, reg_write = 0, lu_op = 0, mem_ack = 0;
  logic [1:0] mem_size = 0, mem_to_reg = 0;
  logic [ADDR_W-1:0] alu_s = 0;
  logic [31:0] mem_wdata_in = 0, pc_plus4 = 0, lu_data = 0, mem_rdata = 0;
  logic [REG_AW-1:0] write_reg = 0;
  logic mem_req, mem_we, stall, misalign_err, bus_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0] mem_be;
  logic [31:0] mem_wdata;
  logic [32+REG_AW:0] mem_wb;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_stage_hs #(.ADDR_W(ADDR_W), .REG_AW(REG_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_b(reset_b), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_signed(mem_signed), .alu_s(alu_s), .mem_wdata_in(mem_wdata_in),
    .write_reg(write_reg), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_plus4(pc_plus4),
    .lu_op(lu_op), .lu_data(lu_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .misalign_err(misalign_err), .bus_err(bus_err), .mem_wb(mem_wb)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    chk("rst_req", mem_req, 0);
    chk("rst_wb", mem_wb, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mis", misalign_err, 0);
    chk("rst_bus", bus_err, 0);
    chk("rst_be", mem_be, 0);
    reset_b = 1;
    // ALU result write-back
    in_valid = 1; alu_s = 32'h1234; write_reg = 7; reg_write = 1; mem_to_reg = 2'b00; lu_op = 0;
    #1 chk("alu_stall", stall, 0);
    step();
    chk("alu_wb", mem_wb, {1'b1, 5'd7, 32'h0000_1234});
    lu_op = 1; lu_data = 32'hDEAD_0000; write_reg = 3;
    step();
    chk("lu_wb", mem_wb, {1'b1, 5'd3, 32'hDEAD_0000});
    lu_op = 0; mem_to_reg = 2'b10; pc_plus4 = 32'h400; write_reg = 31;
    step();
    chk("pc_wb", mem_wb, {1'b1, 5'd31, 32'h0000_0400});
    in_valid = 0; mem_to_reg = 2'b00; alu_s = 32'h55; write_reg = 2;
    step();
    chk("bubble_wb", mem_wb, {1'b0, 5'd2, 32'h0000_0055});
    // signed byte load, ack on third BUSY cycle, inputs scrambled while stalled
    in_valid = 1; mem_read = 1; mem_size = 2'b00; mem_signed = 1; alu_s = 32'h103;
    write_reg = 9; reg_write = 1; mem_to_reg = 2'b01;
    #1 chk("lb_stall0", stall, 1);
    step();
    chk("lb_req", mem_req, 1);
    chk("lb_we", mem_we, 0);
    chk("lb_addr", mem_addr, 32'h100);
    chk("lb_be", mem_be, 4'b1000);
    chk("lb_stall1", stall, 1);
    chk("lb_wb0", mem_wb, 0);
    in_valid = 0; alu_s = 32'hFFF; write_reg = 1; mem_signed = 0; mem_size = 2'b10;
    step();
    chk("lb_stall2", stall, 1);
    chk("lb_addr_hold", mem_addr, 32'h100);
    step();
    mem_ack = 1; mem_rdata = 32'h80FF_FF11;
    #1 chk("lb_stall3", stall, 0);
    step();
    mem_ack = 0;
    chk("lb_wb", mem_wb, {1'b1, 5'd9, 32'hFFFF_FF80});
    chk("lb_req_drop", mem_req, 0);
    // half store, ack on first BUSY cycle
    in_valid = 1; mem_read = 0; mem_write = 1; mem_size = 2'b01; alu_s = 32'h2002;
    mem_wdata_in = 32'h0000_ABCD; write_reg = 4; reg_write = 0; mem_to_reg = 2'b00;
    step();
    chk("sh_addr", mem_addr, 32'h2000);
    chk("sh_be", mem_be, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    chk("sh_we", mem_we, 1);
    in_valid = 0; mem_write = 0; mem_ack = 1;
    #1 chk("sh_stall", stall, 0);
    step();
    mem_ack = 0;
    chk("sh_wb", mem_wb, {1'b0, 5'd4, 32'h0000_2002});
    chk("sh_req_drop", mem_req, 0);
    // unsigned half load at upper lane
    in_valid = 1; mem_read = 1; mem_size = 2'b01; mem_signed = 0; alu_s = 32'h6;
    write_reg = 5; reg_write = 1; mem_to_reg = 2'b01;
    step();
    chk("lhu_be", mem_be, 4'b1100);
    in_valid = 0; mem_ack = 1; mem_rdata = 32'h8765_4321;
    step();
    mem_ack = 0;
    chk("lhu_wb", mem_wb, {1'b1, 5'd5, 32'h0000_8765});
    // misaligned word load
    in_valid = 1; mem_read = 1; mem_size = 2'b10; alu_s = 32'h5; write_reg = 6; reg_write = 1;
    #1 chk("mis_stall", stall, 0);
    step();
    in_valid = 0;
    chk("mis_req", mem_req, 0);
    chk("mis_err", misalign_err, 1);
    chk("mis_wb", mem_wb, 0);
    step();
    chk("mis_pulse", misalign_err, 0);
    // timeout: no ack for TIMEOUT BUSY cycles
    in_valid = 1; mem_read = 1; mem_size = 2'b10; alu_s = 32'h40; write_reg = 8;
    step();
    in_valid = 0;
    for (int i = 1; i < TIMEOUT; i++) begin
      chk($sformatf("to_stall%0d", i), stall, 1);
      step();
    end
    chk("to_last_stall", stall, 0);
    chk("to_last_req", mem_req, 1);
    chk("to_bus_early", bus_err, 0);
    step();
    chk("to_bus", bus_err, 1);
    chk("to_req", mem_req, 0);
    chk("to_wb", mem_wb, 0);
    step();
    chk("to_bus_pulse", bus_err, 0);
    chk("to_idle_stall", stall, 0);
    // reset while BUSY, then a fresh load
    in_valid = 1; mem_read = 1; mem_size = 2'b10; alu_s = 32'h80; write_reg = 12; mem_signed = 0;
    step();
    in_valid = 0;
    chk("rb_req", mem_req, 1);
    #2 reset_b = 0;
    #1 chk("rb_req0", mem_req, 0);
    chk("rb_wb0", mem_wb, 0);
    step();
    chk("rb_bus", bus_err, 0);
    reset_b = 1;
    in_valid = 1; mem_read = 1; mem_size = 2'b10; alu_s = 32'h80; write_reg = 12; reg_write = 1; mem_to_reg = 2'b01;
    step();
    chk("rb_new_req", mem_req, 1);
    in_valid = 0; mem_ack = 1; mem_rdata = 32'hCAFE_BABE;
    step();
    mem_ack = 0;
    chk("rb_new_wb", mem_wb, {1'b1, 5'd12, 32'hCAFE_BABE});
    chk("rb_new_drop", mem_req, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
